// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: decides each cycle whether fetch/decode advance, and
// whether DEC/EX captures the decoded instruction or a bubble. Covers taken
// branch/jump redirects, load-use hazards and the Hi/Lo busy window of the
// multi-cycle multiply/divide unit, and keeps a saturating stall counter.
//
// state    | meaning
// ---------+-----------------------------------------------
// RUN      | MDU counter is 0, Hi/Lo is available
// MDU_BUSY | MDU counter nonzero, Hi/Lo result still pending
module hazard_stall_ctrl #(
    parameter int MDU_CYCLES = 4,
    parameter int COUNT_W    = 16
) (
    input  logic               Clk,
    input  logic               Rst,
    input  logic [4:0]         IDRs,
    input  logic [4:0]         IDRt,
    input  logic               IDUsesRs,
    input  logic               IDUsesRt,
    input  logic               IDIsMdu,
    input  logic               IDReadsHiLo,
    input  logic               EXMemRead,
    input  logic               EXRegWrite,
    input  logic [4:0]         EXWriteReg,
    input  logic               EXBranchTaken,
    input  logic               EXJump,
    output logic               PCWrite,
    output logic               IFIDWrite,
    output logic               IFIDFlush,
    output logic               DECEXFlush,
    output logic               MduStart,
    output logic               MduBusy,
    output logic [COUNT_W-1:0] StallCount
);

    localparam logic [3:0] MDU_LOAD = 4'(MDU_CYCLES);

    typedef enum logic {
        RUN      = 1'b0,
        MDU_BUSY = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [3:0]           mdu_cnt_q, mdu_cnt_d;
    logic                 mdu_busy_q, mdu_busy_d;
    logic                 mdu_start_q, mdu_start_d;
    logic [COUNT_W-1:0]   stall_cnt_q, stall_cnt_d;

    logic redirect;
    logic load_use;
    logic hilo_haz;
    logic stall;
    logic issue;

    // Hazard detection from decode fields and the EX-stage control bits.
    always_comb begin
        redirect = EXBranchTaken | EXJump;
        load_use = EXMemRead & EXRegWrite & (EXWriteReg != 5'd0) &
                   ((IDUsesRs & (IDRs == EXWriteReg)) |
                    (IDUsesRt & (IDRt == EXWriteReg)));
        hilo_haz = mdu_busy_q & (IDIsMdu | IDReadsHiLo);
        stall    = ~redirect & (load_use | hilo_haz);
        issue    = IDIsMdu & ~redirect & ~stall & ~Rst;
    end

    // Pipeline enables and flushes; reset wins, then redirect, then stall.
    always_comb begin
        PCWrite    = 1'b1;
        IFIDWrite  = 1'b1;
        IFIDFlush  = 1'b0;
        DECEXFlush = 1'b0;
        if (Rst) begin
            PCWrite    = 1'b0;
            IFIDWrite  = 1'b0;
            IFIDFlush  = 1'b1;
            DECEXFlush = 1'b1;
        end else if (redirect) begin
            IFIDFlush  = 1'b1;
            DECEXFlush = 1'b1;
        end else if (stall) begin
            PCWrite    = 1'b0;
            IFIDWrite  = 1'b0;
            DECEXFlush = 1'b1;
        end
    end

    // Next state: an issue reloads the window (even on its last cycle); the
    // window keeps counting through stalls and redirects since the op is in EX.
    always_comb begin
        mdu_cnt_d = mdu_cnt_q;
        if (issue) begin
            mdu_cnt_d = MDU_LOAD;
        end else if (state_q == MDU_BUSY) begin
            mdu_cnt_d = mdu_cnt_q - 4'd1;
        end
        state_d     = (mdu_cnt_d != 4'd0) ? MDU_BUSY : RUN;
        mdu_busy_d  = (mdu_cnt_d != 4'd0);
        mdu_start_d = issue;
        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != {COUNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + COUNT_W'(1);
        end
    end

    // State, MDU window and statistics registers with synchronous reset.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q     <= RUN;
            mdu_cnt_q   <= 4'd0;
            mdu_busy_q  <= 1'b0;
            mdu_start_q <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            mdu_cnt_q   <= mdu_cnt_d;
            mdu_busy_q  <= mdu_busy_d;
            mdu_start_q <= mdu_start_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign MduStart   = mdu_start_q;
    assign MduBusy    = mdu_busy_q;
    assign StallCount = stall_cnt_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Bench for hazard_stall_ctrl: directed scenarios followed by random traffic,
// all compared against a cycle-level behavioural model of the hazard rules.
module tb_hazard_stall_ctrl;

    localparam int MDU_N = 4;
    localparam int CW    = 4;
    localparam int SMAX  = (1 << CW) - 1;

    logic          Clk = 1'b0;
    logic          Rst;
    logic [4:0]    IDRs, IDRt, EXWriteReg;
    logic          IDUsesRs, IDUsesRt, IDIsMdu, IDReadsHiLo;
    logic          EXMemRead, EXRegWrite, EXBranchTaken, EXJump;
    logic          PCWrite, IFIDWrite, IFIDFlush, DECEXFlush, MduStart, MduBusy;
    logic [CW-1:0] StallCount;

    int n_tests = 0;
    int n_fail  = 0;

    // model state: cycles of Hi/Lo unavailability left, pending start pulse,
    // stall statistic
    int m_left  = 0;
    bit m_start = 0;
    int m_stall = 0;

    hazard_stall_ctrl #(.MDU_CYCLES(MDU_N), .COUNT_W(CW)) dut (
        .Clk(Clk), .Rst(Rst), .IDRs(IDRs), .IDRt(IDRt),
        .IDUsesRs(IDUsesRs), .IDUsesRt(IDUsesRt), .IDIsMdu(IDIsMdu),
        .IDReadsHiLo(IDReadsHiLo), .EXMemRead(EXMemRead),
        .EXRegWrite(EXRegWrite), .EXWriteReg(EXWriteReg),
        .EXBranchTaken(EXBranchTaken), .EXJump(EXJump),
        .PCWrite(PCWrite), .IFIDWrite(IFIDWrite), .IFIDFlush(IFIDFlush),
        .DECEXFlush(DECEXFlush), .MduStart(MduStart), .MduBusy(MduBusy),
        .StallCount(StallCount)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
        end
    endtask

    task automatic idle_inputs();
        IDRs = 5'd0; IDRt = 5'd0; IDUsesRs = 0; IDUsesRt = 0;
        IDIsMdu = 0; IDReadsHiLo = 0; EXMemRead = 0; EXRegWrite = 0;
        EXWriteReg = 5'd0; EXBranchTaken = 0; EXJump = 0;
    endtask

    // One clock: check outputs mid-cycle against the model, then advance the
    // model by the rules for the edge that follows.
    task automatic cycle();
        bit redir, lu, hz, st, busy, iss;
        int e_pc, e_ifw, e_iff, e_def;
        @(negedge Clk);
        busy  = (m_left > 0);
        redir = EXBranchTaken || EXJump;
        lu    = EXMemRead && EXRegWrite && (EXWriteReg != 0) &&
                ((IDUsesRs && IDRs == EXWriteReg) || (IDUsesRt && IDRt == EXWriteReg));
        hz    = busy && (IDIsMdu || IDReadsHiLo);
        st    = !redir && (lu || hz);
        if (Rst)        begin e_pc = 0; e_ifw = 0; e_iff = 1; e_def = 1; end
        else if (redir) begin e_pc = 1; e_ifw = 1; e_iff = 1; e_def = 1; end
        else if (st)    begin e_pc = 0; e_ifw = 0; e_iff = 0; e_def = 1; end
        else            begin e_pc = 1; e_ifw = 1; e_iff = 0; e_def = 0; end
        chk("PCWrite",    int'(PCWrite),    e_pc);
        chk("IFIDWrite",  int'(IFIDWrite),  e_ifw);
        chk("IFIDFlush",  int'(IFIDFlush),  e_iff);
        chk("DECEXFlush", int'(DECEXFlush), e_def);
        chk("MduStart",   int'(MduStart),   int'(m_start));
        chk("MduBusy",    int'(MduBusy),    int'(busy));
        chk("StallCount", int'(StallCount), m_stall);
        if (Rst) begin
            m_left = 0; m_start = 0; m_stall = 0;
        end else begin
            iss     = IDIsMdu && !redir && !st;
            m_start = iss;
            if (iss)             m_left = MDU_N;
            else if (m_left > 0) m_left = m_left - 1;
            if (st && m_stall < SMAX) m_stall++;
        end
        @(posedge Clk);
        #1;
    endtask

    task automatic set_load_use(input logic [4:0] r);
        EXMemRead = 1; EXRegWrite = 1; EXWriteReg = r;
        IDUsesRs = 1; IDRs = r;
    endtask

    task automatic issue_mult();
        idle_inputs(); IDIsMdu = 1; cycle(); idle_inputs();
    endtask

    initial begin
        idle_inputs();
        Rst = 1;
        @(posedge Clk); #1;
        cycle(); cycle();
        chk("reset_count", int'(StallCount), 0);
        Rst = 0;

        // load-use: one stall, then the bubble clears it
        set_load_use(5'd8); cycle();
        chk("lu_count", int'(StallCount), 1);
        idle_inputs(); IDUsesRs = 1; IDRs = 5'd8; cycle();
        chk("lu_release_pc", int'(PCWrite), 1);
        set_load_use(5'd0); cycle();
        idle_inputs(); EXMemRead = 1; EXRegWrite = 1; EXWriteReg = 5'd9;
        IDUsesRt = 1; IDRt = 5'd9; cycle();
        idle_inputs(); cycle();

        // mult then mfhi: four stalls, advance on the fifth
        issue_mult();
        chk("mdu_start", int'(MduStart), 1);
        IDReadsHiLo = 1;
        repeat (MDU_N + 1) cycle();
        chk("mfhi_count", int'(StallCount), 6);
        idle_inputs(); cycle();

        // mult then div: div stalls four cycles, then issues with no busy gap
        issue_mult();
        IDIsMdu = 1;
        repeat (MDU_N + 1) cycle();
        chk("b2b_start", int'(MduStart), 1);
        chk("b2b_busy",  int'(MduBusy),  1);
        idle_inputs();
        repeat (MDU_N + 1) cycle();

        // redirect beats load-use and suppresses an MDU issue
        set_load_use(5'd3); EXBranchTaken = 1; IDIsMdu = 1; cycle();
        chk("redir_nostart", int'(MduStart), 0);
        chk("redir_count",   int'(StallCount), 10);
        idle_inputs(); cycle();

        // redirect during an MDU window: window keeps running
        issue_mult();
        EXJump = 1; IDReadsHiLo = 1; repeat (2) cycle();
        idle_inputs(); repeat (MDU_N) cycle();

        // reset two cycles into an MDU window
        issue_mult(); cycle();
        Rst = 1; cycle();
        chk("rst_busy",  int'(MduBusy), 0);
        Rst = 0; IDReadsHiLo = 1; cycle();
        chk("rst_nostall", int'(PCWrite), 1);
        idle_inputs();

        // saturation
        set_load_use(5'd12);
        repeat (20) cycle();
        chk("sat_count", int'(StallCount), SMAX);
        idle_inputs(); cycle();

        // random traffic, small register range to make matches common
        for (int i = 0; i < 3000; i++) begin
            Rst           = ($urandom_range(0, 99) == 0);
            IDRs          = 5'($urandom_range(0, 3));
            IDRt          = 5'($urandom_range(0, 3));
            EXWriteReg    = 5'($urandom_range(0, 3));
            IDUsesRs      = 1'($urandom);
            IDUsesRt      = 1'($urandom);
            IDIsMdu       = ($urandom_range(0, 3) == 0);
            IDReadsHiLo   = ($urandom_range(0, 3) == 0);
            EXMemRead     = 1'($urandom);
            EXRegWrite    = 1'($urandom);
            EXBranchTaken = ($urandom_range(0, 7) == 0);
            EXJump        = ($urandom_range(0, 9) == 0);
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
